// File: rtl/pbkdf2_pkg.sv
// ---------------------------------------------------------------------------
// pbkdf2_pkg
// Shared constants and types for the pbkdf2 / HMAC sharing logic.
//   KEY_W, MSG_W, LEN_W, HASH_W : default operand and result widths
//   arb_state_e                 : transaction state of hmac_rr_arbiter
// ---------------------------------------------------------------------------
package pbkdf2_pkg;

  localparam int KEY_W  = 512;
  localparam int MSG_W  = 512;
  localparam int LEN_W  = 6;
  localparam int HASH_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/hmac_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request vector starting
// one position after the pointer, wrapping modulo NUM_REQ.
//   req_i : request vector
//   ptr_i : index of the previous winner
//   gnt_o : one-hot grant (zero when nothing requests)
//   idx_o : index of the granted requester
//   any_o : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  logic [IDX_W:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o                   = 1'b1;
        gnt_o[cand[IDX_W-1:0]]  = 1'b1;
        idx_o                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hmac_rr_arbiter.sv
// ---------------------------------------------------------------------------
// hmac_rr_arbiter
// Shares one HMAC core between NUM_REQ requesters, one transaction at a time.
// A requester is granted by round-robin, its operands are captured locally,
// the core is driven from those registers, and the result is returned only
// to the owning requester.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   req_v_i / req_r_o      : per-requester request valid / grant
//   req_key_i/msg_i/len_i  : packed per-requester operands (req 0 in LSBs)
//   rsp_v_o / rsp_r_i      : per-requester result valid / ready
//   rsp_hash_o             : captured result, broadcast to all requesters
//   hmac_v_o / hmac_r_i    : operand handshake towards the core
//   hmac_key/msg/len_o     : registered operands
//   hmac_v_i / hmac_r_o    : result handshake from the core
//   hmac_hash_i            : core result
//   busy_o, owner_o        : status (transaction active, current owner)
// ---------------------------------------------------------------------------
module hmac_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int KEY_W   = pbkdf2_pkg::KEY_W,
  parameter int MSG_W   = pbkdf2_pkg::MSG_W,
  parameter int LEN_W   = pbkdf2_pkg::LEN_W,
  parameter int HASH_W  = pbkdf2_pkg::HASH_W,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_v_i,
  output logic [NUM_REQ-1:0]       req_r_o,
  input  logic [NUM_REQ*KEY_W-1:0] req_key_i,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  output logic [NUM_REQ-1:0]       rsp_v_o,
  input  logic [NUM_REQ-1:0]       rsp_r_i,
  output logic [HASH_W-1:0]        rsp_hash_o,
  output logic                     hmac_v_o,
  input  logic                     hmac_r_i,
  output logic [KEY_W-1:0]         hmac_key_o,
  output logic [MSG_W-1:0]         hmac_msg_o,
  output logic [LEN_W-1:0]         hmac_len_o,
  input  logic                     hmac_v_i,
  output logic                     hmac_r_o,
  input  logic [HASH_W-1:0]        hmac_hash_i,
  output logic                     busy_o,
  output logic [IDX_W-1:0]         owner_o
);

  import pbkdf2_pkg::*;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, owner_q;
  logic [KEY_W-1:0] key_q;
  logic [MSG_W-1:0] msg_q;
  logic [LEN_W-1:0] len_q;
  logic [HASH_W-1:0] hash_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               grant;
  logic               capture;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i (req_v_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hmac_r_i) state_d = BUSY;
      end
      BUSY: begin
        if (hmac_v_i) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_r_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset pointer to the last index so requester 0 wins the first search.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= IDX_W'(NUM_REQ-1);
      owner_q <= '0;
      key_q   <= '0;
      msg_q   <= '0;
      len_q   <= '0;
      hash_q  <= '0;
    end else begin
      if (grant) begin
        ptr_q   <= pick_idx;
        owner_q <= pick_idx;
        key_q   <= req_key_i[pick_idx*KEY_W +: KEY_W];
        msg_q   <= req_msg_i[pick_idx*MSG_W +: MSG_W];
        len_q   <= req_len_i[pick_idx*LEN_W +: LEN_W];
      end
      if (capture) begin
        hash_q <= hmac_hash_i;
      end
    end
  end

  // The grant is combinational from the requests, so it is also masked while
  // reset is held to keep every output quiet during reset.
  always_comb begin
    req_r_o = '0;
    rsp_v_o = '0;
    if (state_q == IDLE && rst_ni) begin
      req_r_o = pick_gnt;
    end
    if (state_q == RESP) begin
      rsp_v_o[owner_q] = 1'b1;
    end
  end

  assign hmac_v_o   = (state_q == ISSUE);
  assign hmac_r_o   = (state_q == BUSY);
  assign busy_o     = (state_q != IDLE);
  assign owner_o    = owner_q;
  assign hmac_key_o = key_q;
  assign hmac_msg_o = msg_q;
  assign hmac_len_o = len_q;
  assign rsp_hash_o = hash_q;

  // A core result arriving outside BUSY has no transaction to belong to.
  hmacResultOnlyInBusy: assert property (
    @(posedge clk_i) disable iff (!rst_ni) hmac_v_i |-> (state_q == BUSY)
  );

endmodule
